// File: rtl/fim_strobe_xfer_sched.sv
// Source-domain scheduler: round-robin over captured request pulses, one
// crossing strobe per transfer with held ID/data, optional ack wait and gap.
module fim_strobe_xfer_sched #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int MIN_GAP     = 6,
    parameter int USE_ACK     = 1,
    parameter int ACK_TIMEOUT = 64,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic [NUM_REQ-1:0]        req_pulse,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_pending,
    output logic [NUM_REQ-1:0]        req_ovf,
    output logic                      xfer_pulse,
    output logic [ID_W-1:0]           xfer_id,
    output logic [DATA_W-1:0]         xfer_data,
    input  logic                      ack_pulse,
    output logic                      timeout_pulse,
    output logic                      busy
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT);
    localparam int GAP_W = $clog2(MIN_GAP + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, GAP} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] ovf;
    logic [DATA_W-1:0]  hold_data [NUM_REQ];
    logic [ID_W-1:0]    last_grant;
    logic [TMR_W-1:0]   timer;
    logic [GAP_W-1:0]   gap_cnt;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic               grant;
    logic [NUM_REQ-1:0] grant_vec;
    logic               timeout_hit;

    // Two-pass round robin: first look above last_grant, then wrap to the bottom.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_valid && pending[i] && (ID_W'(i) > last_grant)) begin
                win_valid = 1'b1;
                win_id    = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_valid && pending[i]) begin
                win_valid = 1'b1;
                win_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        grant     = (state == IDLE) && win_valid;
        grant_vec = '0;
        if (grant) begin
            grant_vec[win_id] = 1'b1;
        end
    end

    // A new pulse in the grant cycle re-arms pending and is not an overflow.
    always_ff @(posedge clk) begin
        if (srst) begin
            pending <= '0;
            ovf     <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_data[i] <= '0;
            end
        end else begin
            pending <= (pending & ~grant_vec) | req_pulse;
            ovf     <= req_pulse & pending & ~grant_vec;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_pulse[i]) begin
                    hold_data[i] <= req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= IDLE;
            timer      <= '0;
            gap_cnt    <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            xfer_id    <= '0;
            xfer_data  <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= (state == WAIT_ACK) ? timer + 1'b1 : '0;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (grant) begin
                last_grant <= win_id;
                xfer_id    <= win_id;
                xfer_data  <= hold_data[win_id];
            end
        end
    end

    // Ack is only looked at in WAIT_ACK and takes precedence over the timeout.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:     if (win_valid) state_nxt = SEND;
            SEND:     state_nxt = (USE_ACK != 0) ? WAIT_ACK : GAP;
            WAIT_ACK: begin
                if (ack_pulse) begin
                    state_nxt = GAP;
                end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = GAP;
                end
            end
            GAP:      if (gap_cnt == GAP_W'(MIN_GAP - 1)) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign req_pending   = pending;
    assign req_ovf       = ovf;
    assign xfer_pulse    = (state == SEND);
    assign timeout_pulse = timeout_hit;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_fim_strobe_xfer_sched.sv
// Directed bench for fim_strobe_xfer_sched: one instance without ack wait,
// one with ack wait (timeout 64), both with MIN_GAP=6.
module tb_fim_strobe_xfer_sched;

    logic        clk = 1'b0;
    logic        srst;
    logic [3:0]  req_pulse;
    logic [31:0] req_data;
    logic        ack_pulse;
    logic        ack_tie = 1'b0;

    logic [3:0]  n_pending, n_ovf, a_pending, a_ovf;
    logic        n_xfer_pulse, n_timeout, n_busy;
    logic        a_xfer_pulse, a_timeout, a_busy;
    logic [1:0]  n_xfer_id, a_xfer_id;
    logic [7:0]  n_xfer_data, a_xfer_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fim_strobe_xfer_sched #(.NUM_REQ(4), .DATA_W(8), .MIN_GAP(6), .USE_ACK(0), .ACK_TIMEOUT(64)) dut_noack (
        .clk(clk), .srst(srst), .req_pulse(req_pulse), .req_data(req_data),
        .req_pending(n_pending), .req_ovf(n_ovf), .xfer_pulse(n_xfer_pulse),
        .xfer_id(n_xfer_id), .xfer_data(n_xfer_data), .ack_pulse(ack_tie),
        .timeout_pulse(n_timeout), .busy(n_busy)
    );

    fim_strobe_xfer_sched #(.NUM_REQ(4), .DATA_W(8), .MIN_GAP(6), .USE_ACK(1), .ACK_TIMEOUT(64)) dut_ack (
        .clk(clk), .srst(srst), .req_pulse(req_pulse), .req_data(req_data),
        .req_pending(a_pending), .req_ovf(a_ovf), .xfer_pulse(a_xfer_pulse),
        .xfer_id(a_xfer_id), .xfer_data(a_xfer_data), .ack_pulse(ack_pulse),
        .timeout_pulse(a_timeout), .busy(a_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst      = 1'b1;
        req_pulse = '0;
        req_data  = '0;
        ack_pulse = 1'b0;
        step();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({n_pending, n_ovf, n_xfer_pulse, n_timeout, n_busy, n_xfer_id, n_xfer_data} !== 21'd0) begin
            n_err++;
            $display("[TB] FAIL reset_noack: got %h expected 0",
                     {n_pending, n_ovf, n_xfer_pulse, n_timeout, n_busy, n_xfer_id, n_xfer_data});
        end
        n_cmp++;
        if ({a_pending, a_ovf, a_xfer_pulse, a_timeout, a_busy, a_xfer_id, a_xfer_data} !== 21'd0) begin
            n_err++;
            $display("[TB] FAIL reset_ack: got %h expected 0",
                     {a_pending, a_ovf, a_xfer_pulse, a_timeout, a_busy, a_xfer_id, a_xfer_data});
        end
    endtask

    task automatic test_single();
        do_reset();
        req_data  = 32'h00A5_0000;
        req_pulse = 4'b0100;
        step();
        req_pulse = '0;
        n_cmp++;
        if (n_pending !== 4'b0100 || n_xfer_pulse !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL single_pending: got pend=%b pulse=%b expected pend=0100 pulse=0", n_pending, n_xfer_pulse);
        end
        step();
        n_cmp++;
        if (n_xfer_pulse !== 1'b1 || n_xfer_id !== 2'd2 || n_xfer_data !== 8'hA5 || n_busy !== 1'b1 || n_pending !== 4'b0000) begin
            n_err++;
            $display("[TB] FAIL single_strobe: got pulse=%b id=%0d data=%h busy=%b pend=%b expected 1/2/a5/1/0000",
                     n_xfer_pulse, n_xfer_id, n_xfer_data, n_busy, n_pending);
        end
        for (int c = 3; c <= 9; c++) begin
            step();
            n_cmp++;
            if (n_xfer_pulse !== 1'b0 || n_busy !== (c <= 8) || n_xfer_id !== 2'd2 || n_xfer_data !== 8'hA5) begin
                n_err++;
                $display("[TB] FAIL single_gap c%0d: got pulse=%b busy=%b id=%0d data=%h expected 0/%0d/2/a5",
                         c, n_xfer_pulse, n_busy, n_xfer_id, n_xfer_data, (c <= 8));
            end
        end
    endtask

    task automatic test_round_robin();
        int         ns;
        int         scyc [8];
        logic [1:0] sid  [8];
        logic [7:0] sdat [8];
        do_reset();
        ns        = 0;
        req_data  = 32'h4332_2110;
        req_pulse = 4'b1111;
        for (int c = 1; c <= 34; c++) begin
            step();
            req_pulse = '0;
            if (n_xfer_pulse === 1'b1 && ns < 8) begin
                scyc[ns] = c; sid[ns] = n_xfer_id; sdat[ns] = n_xfer_data; ns++;
            end
        end
        n_cmp++;
        if (ns !== 4) begin
            n_err++;
            $display("[TB] FAIL rr_count: got %0d strobes expected 4", ns);
        end
        for (int k = 0; k < 4 && k < ns; k++) begin
            n_cmp++;
            if (scyc[k] !== 2 + 8 * k || sid[k] !== 2'(k) || sdat[k] !== 8'(8'h10 + 8'h11 * k)) begin
                n_err++;
                $display("[TB] FAIL rr_strobe%0d: got cyc=%0d id=%0d data=%h expected cyc=%0d id=%0d data=%h",
                         k, scyc[k], sid[k], sdat[k], 2 + 8 * k, k, 8'(8'h10 + 8'h11 * k));
            end
        end
        ns        = 0;
        req_data  = 32'hD300_00C0;
        req_pulse = 4'b1001;
        for (int c = 1; c <= 12; c++) begin
            step();
            req_pulse = '0;
            if (n_xfer_pulse === 1'b1 && ns < 8) begin
                scyc[ns] = c; sid[ns] = n_xfer_id; sdat[ns] = n_xfer_data; ns++;
            end
        end
        n_cmp++;
        if (ns !== 2 || scyc[0] !== 2 || sid[0] !== 2'd0 || sdat[0] !== 8'hC0
            || scyc[1] !== 10 || sid[1] !== 2'd3 || sdat[1] !== 8'hD3) begin
            n_err++;
            $display("[TB] FAIL rr_pair: got n=%0d first=%0d@%0d second=%0d@%0d expected n=2 first=0@2 second=3@10",
                     ns, sid[0], scyc[0], sid[1], scyc[1]);
        end
    endtask

    task automatic test_coalesce();
        int ns;
        int scyc;
        logic [1:0] sid;
        logic [7:0] sdat;
        do_reset();
        ns = 0; scyc = -1; sid = '0; sdat = '0;
        req_data  = 32'h0000_1101;
        req_pulse = 4'b0011;
        step();
        req_pulse = '0;
        step();
        n_cmp++;
        if (n_xfer_pulse !== 1'b1 || n_xfer_id !== 2'd0 || n_xfer_data !== 8'h01) begin
            n_err++;
            $display("[TB] FAIL coal_first: got pulse=%b id=%0d data=%h expected 1/0/01", n_xfer_pulse, n_xfer_id, n_xfer_data);
        end
        step();
        req_data  = 32'h0000_2200;
        req_pulse = 4'b0010;
        n_cmp++;
        if (n_ovf !== 4'b0000) begin
            n_err++;
            $display("[TB] FAIL coal_ovf_c3: got %b expected 0000", n_ovf);
        end
        step();
        req_pulse = '0;
        n_cmp++;
        if (n_ovf !== 4'b0010) begin
            n_err++;
            $display("[TB] FAIL coal_ovf_c4: got %b expected 0010", n_ovf);
        end
        step();
        n_cmp++;
        if (n_ovf !== 4'b0000) begin
            n_err++;
            $display("[TB] FAIL coal_ovf_c5: got %b expected 0000", n_ovf);
        end
        for (int c = 6; c <= 25; c++) begin
            step();
            if (n_xfer_pulse === 1'b1) begin
                ns++; scyc = c; sid = n_xfer_id; sdat = n_xfer_data;
            end
        end
        n_cmp++;
        if (ns !== 1 || scyc !== 10 || sid !== 2'd1 || sdat !== 8'h22) begin
            n_err++;
            $display("[TB] FAIL coal_xfer: got n=%0d cyc=%0d id=%0d data=%h expected n=1 cyc=10 id=1 data=22",
                     ns, scyc, sid, sdat);
        end
    endtask

    task automatic test_collision();
        do_reset();
        req_data  = 32'h0000_0001;
        req_pulse = 4'b0001;
        step();
        req_data  = 32'h0000_0002;
        req_pulse = 4'b0001;
        step();
        req_pulse = '0;
        n_cmp++;
        if (n_xfer_pulse !== 1'b1 || n_xfer_data !== 8'h01 || n_pending !== 4'b0001 || n_ovf !== 4'b0000) begin
            n_err++;
            $display("[TB] FAIL coll_grant: got pulse=%b data=%h pend=%b ovf=%b expected 1/01/0001/0000",
                     n_xfer_pulse, n_xfer_data, n_pending, n_ovf);
        end
        for (int c = 3; c <= 12; c++) begin
            step();
            n_cmp++;
            if (n_xfer_pulse !== (c == 10) || (c == 10 && (n_xfer_id !== 2'd0 || n_xfer_data !== 8'h02))) begin
                n_err++;
                $display("[TB] FAIL coll_second c%0d: got pulse=%b id=%0d data=%h expected pulse=%0d id=0 data=02",
                         c, n_xfer_pulse, n_xfer_id, n_xfer_data, (c == 10));
            end
        end
    endtask

    task automatic test_ack();
        int ns;
        int scyc;
        int tcnt;
        logic [1:0] sid;
        logic [7:0] sdat;
        do_reset();
        ns = 0; scyc = -1; tcnt = 0; sid = '0; sdat = '0;
        req_data  = 32'h0000_5C00;
        req_pulse = 4'b0010;
        step();
        req_data  = 32'h6E00_0000;
        req_pulse = 4'b1000;
        step();
        req_pulse = '0;
        ack_pulse = 1'b1;
        n_cmp++;
        if (a_xfer_pulse !== 1'b1 || a_xfer_id !== 2'd1 || a_xfer_data !== 8'h5C) begin
            n_err++;
            $display("[TB] FAIL ack_strobe: got pulse=%b id=%0d data=%h expected 1/1/5c", a_xfer_pulse, a_xfer_id, a_xfer_data);
        end
        for (int c = 3; c <= 22; c++) begin
            step();
            ack_pulse = (c == 12);
            #1;
            if (a_timeout === 1'b1) tcnt++;
            if (a_xfer_pulse === 1'b1) begin
                ns++; scyc = c; sid = a_xfer_id; sdat = a_xfer_data;
            end
        end
        ack_pulse = 1'b0;
        n_cmp++;
        if (tcnt !== 0) begin
            n_err++;
            $display("[TB] FAIL ack_no_timeout: got %0d timeout pulses expected 0", tcnt);
        end
        n_cmp++;
        if (ns !== 1 || scyc !== 20 || sid !== 2'd3 || sdat !== 8'h6E) begin
            n_err++;
            $display("[TB] FAIL ack_next: got n=%0d cyc=%0d id=%0d data=%h expected n=1 cyc=20 id=3 data=6e",
                     ns, scyc, sid, sdat);
        end
    endtask

    task automatic test_timeout(input bool_ack_at_limit);
        int tcnt;
        int tcyc;
        do_reset();
        tcnt = 0; tcyc = -1;
        req_data  = bool_ack_at_limit ? 32'h0000_003D : 32'h007E_0000;
        req_pulse = bool_ack_at_limit ? 4'b0001 : 4'b0100;
        step();
        req_pulse = '0;
        step();
        n_cmp++;
        if (a_xfer_pulse !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL to_strobe: got pulse=%b expected 1", a_xfer_pulse);
        end
        for (int c = 3; c <= 73; c++) begin
            step();
            ack_pulse = bool_ack_at_limit && (c == 66);
            #1;
            if (a_timeout === 1'b1) begin
                tcnt++;
                tcyc = c;
                n_cmp++;
                if (a_xfer_id !== 2'd2 || a_xfer_data !== 8'h7E) begin
                    n_err++;
                    $display("[TB] FAIL to_hold: got id=%0d data=%h expected 2/7e", a_xfer_id, a_xfer_data);
                end
            end
            if (c == 67 || c == 73) begin
                n_cmp++;
                if (a_busy !== (c == 67)) begin
                    n_err++;
                    $display("[TB] FAIL to_busy c%0d: got %b expected %0d", c, a_busy, (c == 67));
                end
            end
        end
        ack_pulse = 1'b0;
        n_cmp++;
        if (bool_ack_at_limit ? (tcnt !== 0) : (tcnt !== 1 || tcyc !== 66)) begin
            n_err++;
            $display("[TB] FAIL to_pulse ack=%0d: got n=%0d cyc=%0d expected n=%0d cyc=66",
                     bool_ack_at_limit, tcnt, tcyc, bool_ack_at_limit ? 0 : 1);
        end
    endtask

    task automatic test_reset_mid();
        int ns;
        do_reset();
        ns = 0;
        req_data  = 32'h4433_229A;
        req_pulse = 4'b1111;
        step();
        req_pulse = '0;
        for (int c = 2; c <= 5; c++) step();
        n_cmp++;
        if (a_busy !== 1'b1 || a_xfer_data !== 8'h9A || a_pending !== 4'b1110) begin
            n_err++;
            $display("[TB] FAIL mid_pre: got busy=%b data=%h pend=%b expected 1/9a/1110", a_busy, a_xfer_data, a_pending);
        end
        srst = 1'b1;
        step();
        srst = 1'b0;
        n_cmp++;
        if ({a_pending, a_ovf, a_xfer_pulse, a_timeout, a_busy, a_xfer_id, a_xfer_data} !== 21'd0) begin
            n_err++;
            $display("[TB] FAIL mid_reset: got %h expected 0",
                     {a_pending, a_ovf, a_xfer_pulse, a_timeout, a_busy, a_xfer_id, a_xfer_data});
        end
        for (int c = 7; c <= 86; c++) begin
            step();
            if (a_xfer_pulse === 1'b1 || a_busy === 1'b1) ns++;
        end
        n_cmp++;
        if (ns !== 0) begin
            n_err++;
            $display("[TB] FAIL mid_quiet: got %0d active cycles expected 0", ns);
        end
        req_pulse = 4'b0010;
        step();
        req_pulse = '0;
        step();
        n_cmp++;
        if (a_xfer_pulse !== 1'b1 || a_xfer_id !== 2'd1 || a_xfer_data !== 8'h22) begin
            n_err++;
            $display("[TB] FAIL mid_restart: got pulse=%b id=%0d data=%h expected 1/1/22", a_xfer_pulse, a_xfer_id, a_xfer_data);
        end
    endtask

    initial begin
        srst      = 1'b1;
        req_pulse = '0;
        req_data  = '0;
        ack_pulse = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_coalesce();
        test_collision();
        test_ack();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fim_strobe_xfer_sched.md
# fim_strobe_xfer_sched

Source-domain scheduler that lets NUM_REQ requesters share one pulse-crossing channel (a toggle-based strobe crossing plus a held ID/data bus captured as a multicycle path). It does four things:
- Captures single-cycle request pulses and their payloads.
- Arbitrates round-robin.
- Drives exactly one crossing strobe per transfer, holding ID/data stable until the next strobe.
- Enforces a minimum strobe spacing, so the destination synchronizer can never merge two strobes.

Optionally it waits for a returned, already-synchronized acknowledge pulse, with a timeout.

## Interface
Parameters:
- NUM_REQ, 4 — number of requesters, 2..16.
- DATA_W, 8 — payload width per requester.
- MIN_GAP, 6 — idle cycles enforced after each transfer completes, ≥1.
- USE_ACK, 1 — 1: wait for ack_pulse after each strobe; 0: no wait.
- ACK_TIMEOUT, 64 — cycles to wait for ack before abandoning, ≥2.
- ID_W, derived — $clog2(NUM_REQ).

Ports:
- clk — in, 1 — single clock; all logic is synchronous to it.
- srst — in, 1 — synchronous, active-high reset.
- req_pulse — in, NUM_REQ — one-cycle request per requester.
- req_data — in, NUM_REQ*DATA_W — payload, sampled on the req_pulse cycle; requester i uses bits [i*DATA_W +: DATA_W].
- req_pending — out, NUM_REQ — request captured, not yet granted.
- req_ovf — out, NUM_REQ — one-cycle flag: a request arrived while already pending (coalesced).
- xfer_pulse — out, 1 — one-cycle strobe to the crossing's din_pulse.
- xfer_id — out, ID_W — granted requester index, held.
- xfer_data — out, DATA_W — granted payload, held.
- ack_pulse — in, 1 — destination acknowledge, already in clk domain.
- timeout_pulse — out, 1 — one-cycle flag: ack not received within ACK_TIMEOUT.
- busy — out, 1 — FSM not in IDLE.

## Operation
Capture:
- req_pulse[i] sets pending[i] and loads hold_data[i] from req_data (latest payload wins).
- If pending[i] is already set, req_ovf[i] pulses the next cycle.
- Set beats clear: a req_pulse[i] in the same cycle that i is granted re-sets pending[i], loads the new data, and does not flag req_ovf.

Arbitration:
- Round-robin over pending, searching from last_grant+1 with wrap-around.
- last_grant resets to NUM_REQ-1, so requester 0 has first priority.

FSM states:
- IDLE: if any pending bit is set, pick winner w, clear pending[w], register xfer_id=w and xfer_data=hold_data[w], assert xfer_pulse next cycle, go to SEND.
- SEND (xfer_pulse=1, exactly one cycle): if USE_ACK, go to WAIT_ACK and clear the timer; otherwise go to GAP.
- WAIT_ACK: on ack_pulse, go to GAP. Otherwise, when timer reaches ACK_TIMEOUT-1, pulse timeout_pulse and go to GAP. If ack_pulse and timeout occur in the same cycle, ack wins and timeout_pulse stays 0.
- GAP: count MIN_GAP cycles, then return to IDLE.

Ack and data rules:
- ack_pulse outside WAIT_ACK, including in SEND, is ignored.
- xfer_id and xfer_data change only on the cycle xfer_pulse rises. Otherwise they hold, including through timeout.

Reset:
- All outputs are 0 on the cycle after srst is sampled high: xfer_pulse, req_pending, req_ovf, timeout_pulse, busy, xfer_id, xfer_data.
- Pending requests are discarded.
- Reset during SEND, WAIT_ACK or GAP returns the FSM to IDLE with no further strobe.

## Timing
- req_pulse[i] at cycle 0 → req_pending[i]=1 at cycle 1 → xfer_pulse at cycle 2 (when idle and i wins).
- USE_ACK=0: the next xfer_pulse comes no earlier than MIN_GAP+2 cycles after the previous one.
- USE_ACK=1, ack at cycle k after the strobe: the next strobe comes no earlier than k+MIN_GAP+1 cycles after the strobe.
- Timeout: timeout_pulse fires ACK_TIMEOUT cycles after the xfer_pulse cycle.
- Throughput with all requesters pending: one grant per transfer period, with strict rotation 0,1,…,NUM_REQ-1,0.

## Test plan
1. **Single request, no ack:** USE_ACK=0, MIN_GAP=6; req_pulse[2] with data 0xA5 at cycle 0 → xfer_pulse at cycle 2, xfer_id=2, xfer_data=0xA5, busy for cycles 2..8, IDLE at cycle 9.
2. **Round-robin, all pending:** req_pulse=4'b1111 at once → strobes in order 0,1,2,3, each MIN_GAP+2 cycles apart; then req_pulse[0] and req_pulse[3] together → 0 first.
3. **Coalescing:** req_pulse[1] at cycles 0 and 3, with data 0x11 then 0x22, while the FSM is busy on requester 0 → req_ovf[1] at cycle 4; a single transfer for requester 1 carries 0x22.
4. **Ack and timeout:** USE_ACK=1, ACK_TIMEOUT=64.
   - ack_pulse 10 cycles after the strobe → no timeout_pulse; next strobe ≥10+MIN_GAP+1 cycles after.
   - No ack → timeout_pulse exactly 64 cycles after the strobe; xfer_id and xfer_data unchanged.
   - ack and timeout in the same cycle → no timeout_pulse.
5. **Grant collision:** req_pulse[0] in the same cycle requester 0 is granted → req_pending[0]=1 afterwards, no req_ovf, second transfer follows.
6. **Reset mid-transfer:** srst in WAIT_ACK with 3 requests pending → all outputs 0 next cycle, no xfer_pulse until a new req_pulse.
